// File: rtl/sram_model.sv
// Single-port synchronous SRAM model with registered read data.
//
// One access per rising clk edge: cs=1/we=1 writes din into word ad; cs=1/we=0 loads word ad
// into dout, so read data appears one cycle after the address. Addresses at or beyond DEPTH
// (only possible when DEPTH is not a power of two) drop writes and read as zero. rst is
// synchronous and active-high. It clears dout and wins over any access in the same cycle.
//
// Configuration macro: SRAM_MODEL_RESET_CLEAR_EN
//   defined   - rst also clears every memory word to zero.
//   undefined - memory contents survive rst (default).

module sram_model #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cs,
   input  logic                             we,
   input  logic [$clog2(DEPTH)-1:0]         ad,
   input  logic [WIDTH-1:0]                 din,
   output logic [WIDTH-1:0]                 dout
);

   localparam int unsigned DEPTH_LOG = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             in_range;
   logic             wr_en;
   logic             rd_en;

   // Address decode: a power-of-two DEPTH covers every code of ad, so no compare is needed.
   if (DEPTH == (1 << DEPTH_LOG)) begin : g_full_range
      assign in_range = 1'b1;
   end else begin : g_partial_range
      localparam logic [DEPTH_LOG:0] DEPTH_CMP = DEPTH[DEPTH_LOG:0];
      assign in_range = ({1'b0, ad} < DEPTH_CMP);
   end

   // Access qualification; out-of-range writes are dropped here so memory never sees them.
   always_comb begin
      wr_en = cs & we & in_range;
      rd_en = cs & ~we;
   end

   // Memory array update; reset has priority and discards a concurrent write.
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef SRAM_MODEL_RESET_CLEAR_EN
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
`endif
      end else if (wr_en) begin
         mem[ad] <= din;
      end
   end

   // Registered read port; holds its value on every non-read cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else if (rd_en) begin
         dout <= in_range ? mem[ad] : '0;
      end
   end

endmodule

// File: tb/tb_sram_model.sv
// Scoreboard bench for sram_model. Two instances: DEPTH=8 for the main function and DEPTH=6
// for out-of-range addressing. The driver pushes the hand-computed dout expected after each
// edge; a monitor on the falling edge pops and compares.

module tb_sram_model;

   logic        clk;
   logic        rst8, cs8, we8;
   logic [2:0]  ad8;
   logic [31:0] din8, dout8;
   logic        rst6, cs6, we6;
   logic [2:0]  ad6;
   logic [31:0] din6, dout6;

   typedef struct {
      int          due;
      bit          sel;   // 0: DEPTH=8 instance, 1: DEPTH=6 instance
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cycle;
   int   vectors;
   int   miscompares;

   sram_model #(.DEPTH(8), .WIDTH(32)) dut8 (
      .clk  (clk),
      .rst  (rst8),
      .cs   (cs8),
      .we   (we8),
      .ad   (ad8),
      .din  (din8),
      .dout (dout8)
   );

   sram_model #(.DEPTH(6), .WIDTH(32)) dut6 (
      .clk  (clk),
      .rst  (rst6),
      .cs   (cs6),
      .we   (we6),
      .ad   (ad6),
      .din  (din6),
      .dout (dout6)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   // Monitor: compare every expectation that falls due on this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cycle) begin
         exp_t        e;
         logic [31:0] act;
         e = sb.pop_front();
         act = e.sel ? dout6 : dout8;
         vectors++;
         if (act !== e.exp) begin
            miscompares++;
            $display("FAIL %s: dout=0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.exp,
                     cycle);
         end
      end
   end

   // Drive one cycle on the selected instance (other deselected) and queue the expected dout.
   task automatic step(input bit sel, input bit r, input bit c, input bit w,
                       input logic [2:0] a, input logic [31:0] d, input logic [31:0] e,
                       input string name);
      exp_t x;
      if (sel) begin
         rst6 = r; cs6 = c; we6 = w; ad6 = a; din6 = d;
         rst8 = 1'b0; cs8 = 1'b0; we8 = 1'b0;
      end else begin
         rst8 = r; cs8 = c; we8 = w; ad8 = a; din8 = d;
         rst6 = 1'b0; cs6 = 1'b0; we6 = 1'b0;
      end
      x.due  = cycle + 1;
      x.sel  = sel;
      x.exp  = e;
      x.name = name;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_after_rst2;
   logic [31:0] exp_after_rst5;

   initial begin
      cycle = 0; vectors = 0; miscompares = 0;
      rst8 = 1'b0; cs8 = 1'b0; we8 = 1'b0; ad8 = '0; din8 = '0;
      rst6 = 1'b0; cs6 = 1'b0; we6 = 1'b0; ad6 = '0; din6 = '0;
`ifdef SRAM_MODEL_RESET_CLEAR_EN
      exp_after_rst2 = 32'h0;
      exp_after_rst5 = 32'h0;
`else
      exp_after_rst2 = 32'h12;
      exp_after_rst5 = 32'hA5A5A5A5;
`endif

      // Reset both instances; rst wins over a concurrent read.
      step(0, 1, 1, 0, 3'd0, 32'h0, 32'h0, "reset8");
      step(1, 1, 1, 0, 3'd0, 32'h0, 32'h0, "reset6");

      // Sequential writes; dout holds 0 throughout.
      for (int i = 0; i < 8; i++)
         step(0, 0, 1, 1, 3'(i), 32'h10 + 32'(i), 32'h0, "write_hold");
      // Sequential reads, each one cycle after its address.
      for (int i = 0; i < 8; i++)
         step(0, 0, 1, 0, 3'(i), 32'h0, 32'h10 + 32'(i), "seq_read");

      // Deselected write attempts: no memory change, dout holds.
      step(0, 0, 0, 1, 3'd3, 32'hDEAD, 32'h17, "cs0_hold");
      step(0, 0, 0, 0, 3'd0, 32'hDEAD, 32'h17, "cs0_hold2");
      step(0, 0, 1, 0, 3'd3, 32'h0, 32'h13, "cs0_no_write");

      // Write then read the same address on the next cycle.
      step(0, 0, 1, 1, 3'd5, 32'hA5A5A5A5, 32'h13, "wr_hold");
      step(0, 0, 1, 0, 3'd5, 32'h0, 32'hA5A5A5A5, "rd_after_wr");
      step(0, 0, 0, 0, 3'd0, 32'h0, 32'hA5A5A5A5, "idle_hold");

      // Full-width write.
      step(0, 0, 1, 1, 3'd0, 32'hFFFFFFFF, 32'hA5A5A5A5, "full_wr_hold");
      step(0, 0, 1, 0, 3'd0, 32'h0, 32'hFFFFFFFF, "full_width");

      // Reset mid-operation, concurrent write discarded.
      step(0, 0, 1, 0, 3'd1, 32'h0, 32'h11, "pre_rst_read");
      step(0, 1, 1, 1, 3'd2, 32'hFF, 32'h0, "rst_with_write");
      step(0, 0, 1, 0, 3'd2, 32'h0, exp_after_rst2, "post_rst_read2");
      step(0, 0, 1, 0, 3'd5, 32'h0, exp_after_rst5, "post_rst_read5");

      // DEPTH=6: fill, then out-of-range writes and reads.
      for (int i = 0; i < 6; i++)
         step(1, 0, 1, 1, 3'(i), 32'h20 + 32'(i), 32'h0, "d6_write_hold");
      step(1, 0, 1, 1, 3'd6, 32'hBAD6, 32'h0, "d6_oor_wr6");
      step(1, 0, 1, 1, 3'd7, 32'hBAD7, 32'h0, "d6_oor_wr7");
      step(1, 0, 1, 0, 3'd5, 32'h0, 32'h25, "d6_read5");
      step(1, 0, 1, 0, 3'd7, 32'h0, 32'h0, "d6_oor_rd7");
      step(1, 0, 1, 0, 3'd4, 32'h0, 32'h24, "d6_read4");
      step(1, 0, 1, 0, 3'd6, 32'h0, 32'h0, "d6_oor_rd6");
      for (int i = 0; i < 6; i++)
         step(1, 0, 1, 0, 3'(i), 32'h0, 32'h20 + 32'(i), "d6_unchanged");

      cs8 = 1'b0; cs6 = 1'b0; rst8 = 1'b0; rst6 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
         miscompares += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
